// File: rtl/hwpe_ctrl_package.sv
// Shared types and constants for the HWPE control job scheduler.
package hwpe_ctrl_package;

    localparam int unsigned REGFILE_N_CONTEXT = 2;

    // Values the regfile returns on a refused acquire read.
    localparam int RESP_ANOTHER_PE_OFFLOADING = -2;
    localparam int RESP_ALL_CXT_BUSY          = -1;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_START,
        SCHED_RUN,
        SCHED_DONE
    } sched_state_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_ptr.sv
// Wrapping modulo-N_CONTEXT context index with increment and soft clear.
module hwpe_ctrl_ctx_ptr #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned CTX_W     = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             incr_i,
    output logic [CTX_W-1:0] idx_o
);

    localparam logic [CTX_W-1:0] LAST = CTX_W'(N_CONTEXT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_o <= '0;
        end else if (clear_i) begin
            idx_o <= '0;
        end else if (incr_i) begin
            idx_o <= (idx_o == LAST) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/hwpe_ctrl_job_scheduler.sv
// Offload lock arbitration and job sequencing over the regfile contexts.
// Optional cycle counter enabled with HWPE_CTRL_SCHED_PERF_EN.
module hwpe_ctrl_job_scheduler
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int unsigned ID_WIDTH  = 16,
    localparam int unsigned CTX_W    = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                acquire_i,
    input  logic [ID_WIDTH-1:0] acquire_src_i,
    input  logic                trigger_i,
    input  logic [ID_WIDTH-1:0] trigger_src_i,
    input  logic                engine_done_i,
    output logic                is_critical_o,
    output logic                full_context_o,
    output logic                acquire_grant_o,
    output logic                trigger_err_o,
    output logic [CTX_W-1:0]    pointer_context_o,
    output logic [CTX_W-1:0]    running_context_o,
    output logic                engine_start_o,
    output logic                true_done_o,
    output logic                evt_o,
    output logic [ID_WIDTH-1:0] evt_src_o,
    output logic                busy_o
`ifdef HWPE_CTRL_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);

    sched_state_t        state;
    logic                lock;
    logic [ID_WIDTH-1:0] owner;
    logic [CNT_W-1:0]    cnt;
    logic [ID_WIDTH-1:0] ctx_src [N_CONTEXT];

    logic acq_ok;
    logic trig_ok;
    logic done_exit;

    assign is_critical_o  = lock;
    assign full_context_o = (cnt == CNT_W'(N_CONTEXT));
    assign busy_o         = (cnt != '0) | (state != SCHED_IDLE);

    // Both decisions use pre-cycle state, so they are mutually exclusive on lock.
    assign acq_ok    = acquire_i & ~lock & ~full_context_o;
    assign trig_ok   = trigger_i & lock & (trigger_src_i == owner);
    assign done_exit = (state == SCHED_DONE);

    hwpe_ctrl_ctx_ptr #(.N_CONTEXT(N_CONTEXT), .CTX_W(CTX_W)) i_pointer_ctx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .incr_i  (trig_ok),
        .idx_o   (pointer_context_o)
    );

    hwpe_ctrl_ctx_ptr #(.N_CONTEXT(N_CONTEXT), .CTX_W(CTX_W)) i_running_ctx (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .incr_i  (done_exit),
        .idx_o   (running_context_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= SCHED_IDLE;
            lock            <= 1'b0;
            owner           <= '0;
            cnt             <= '0;
            acquire_grant_o <= 1'b0;
            trigger_err_o   <= 1'b0;
            engine_start_o  <= 1'b0;
            true_done_o     <= 1'b0;
            evt_o           <= 1'b0;
            evt_src_o       <= '0;
            for (int unsigned i = 0; i < N_CONTEXT; i++) ctx_src[i] <= '0;
        end else if (clear_i) begin
            state           <= SCHED_IDLE;
            lock            <= 1'b0;
            owner           <= '0;
            cnt             <= '0;
            acquire_grant_o <= 1'b0;
            trigger_err_o   <= 1'b0;
            engine_start_o  <= 1'b0;
            true_done_o     <= 1'b0;
            evt_o           <= 1'b0;
            evt_src_o       <= '0;
            for (int unsigned i = 0; i < N_CONTEXT; i++) ctx_src[i] <= '0;
        end else begin
            acquire_grant_o <= acq_ok;
            trigger_err_o   <= trigger_i & ~trig_ok;
            engine_start_o  <= 1'b0;
            true_done_o     <= 1'b0;
            evt_o           <= 1'b0;

            if (trig_ok) begin
                ctx_src[pointer_context_o] <= owner;
                lock                       <= 1'b0;
            end
            if (acq_ok) begin
                lock  <= 1'b1;
                owner <= acquire_src_i;
            end

            // A commit coinciding with a retiring job leaves occupancy unchanged.
            case ({trig_ok, done_exit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            case (state)
                SCHED_IDLE: begin
                    if (cnt != '0) begin
                        state          <= SCHED_START;
                        engine_start_o <= 1'b1;
                    end
                end
                SCHED_START: state <= SCHED_RUN;
                SCHED_RUN: begin
                    if (engine_done_i) begin
                        state       <= SCHED_DONE;
                        true_done_o <= 1'b1;
                        evt_o       <= 1'b1;
                        evt_src_o   <= ctx_src[running_context_o];
                    end
                end
                SCHED_DONE: state <= SCHED_IDLE;
                default:    state <= SCHED_IDLE;
            endcase
        end
    end

`ifdef HWPE_CTRL_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_o <= '0;
        end else if (clear_i | acq_ok) begin
            perf_cnt_o <= '0;
        end else if ((state != SCHED_IDLE) && (perf_cnt_o != '1)) begin
            perf_cnt_o <= perf_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hwpe_ctrl_job_scheduler.sv
// Scoreboard bench for hwpe_ctrl_job_scheduler: transaction-level model feeds
// expected pulses and per-cycle levels; an independent monitor compares them.
module tb_hwpe_ctrl_job_scheduler;

    localparam int NCTX = 2;
    localparam int IDW  = 16;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clear_i = 1'b0;
    logic            acquire_i = 1'b0;
    logic [IDW-1:0]  acquire_src_i = '0;
    logic            trigger_i = 1'b0;
    logic [IDW-1:0]  trigger_src_i = '0;
    logic            engine_done_i = 1'b0;
    logic            is_critical_o, full_context_o, acquire_grant_o, trigger_err_o;
    logic [0:0]      pointer_context_o, running_context_o;
    logic            engine_start_o, true_done_o, evt_o, busy_o;
    logic [IDW-1:0]  evt_src_o;
`ifdef HWPE_CTRL_SCHED_PERF_EN
    logic [31:0]     perf_cnt_o;
`endif

    always #5 clk = ~clk;

    hwpe_ctrl_job_scheduler #(.N_CONTEXT(NCTX), .ID_WIDTH(IDW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .clear_i           (clear_i),
        .acquire_i         (acquire_i),
        .acquire_src_i     (acquire_src_i),
        .trigger_i         (trigger_i),
        .trigger_src_i     (trigger_src_i),
        .engine_done_i     (engine_done_i),
        .is_critical_o     (is_critical_o),
        .full_context_o    (full_context_o),
        .acquire_grant_o   (acquire_grant_o),
        .trigger_err_o     (trigger_err_o),
        .pointer_context_o (pointer_context_o),
        .running_context_o (running_context_o),
        .engine_start_o    (engine_start_o),
        .true_done_o       (true_done_o),
        .evt_o             (evt_o),
        .evt_src_o         (evt_src_o),
        .busy_o            (busy_o)
`ifdef HWPE_CTRL_SCHED_PERF_EN
        ,
        .perf_cnt_o        (perf_cnt_o)
`endif
    );

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int       ed;
        bit       crit;
        bit       full;
        bit       busy;
        int       ptr;
        int       run;
        int       perf;
        logic [IDW-1:0] src;
    } snap_t;

    snap_t          q_lvl[$];
    int             q_grant[$], q_err[$], q_start[$], q_evt[$];
    logic [IDW-1:0] q_src[$];

    // Reference model: lock/owner, FIFO of committed jobs, and the active job's timestamps.
    bit             m_locked = 0;
    logic [IDW-1:0] m_owner = '0;
    int             m_occ = 0, m_trig = 0, m_retired = 0, m_perf = 0;
    bit             m_active = 0, m_done_seen = 0;
    int             m_start = 0, m_done_edge = 0;
    logic [IDW-1:0] m_jobs[$];
    logic [IDW-1:0] m_last_src = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    task automatic step(input bit clr, input bit acq, input logic [IDW-1:0] asrc,
                        input bit trg, input logic [IDW-1:0] tsrc, input bit dn);
        int k;
        bit grant, tok, was_active;
        int delta;
        snap_t s;
        k = edge_cnt + 1;
        clear_i = clr; acquire_i = acq; acquire_src_i = asrc;
        trigger_i = trg; trigger_src_i = tsrc; engine_done_i = dn;
        was_active = m_active;
        if (clr) begin
            m_locked = 0; m_owner = '0; m_occ = 0; m_trig = 0; m_retired = 0;
            m_active = 0; m_done_seen = 0; m_jobs.delete(); m_perf = 0; m_last_src = '0;
        end else begin
            grant = acq && !m_locked && (m_occ < NCTX);
            tok   = trg && m_locked && (tsrc == m_owner);
            if (grant) q_grant.push_back(k);
            if (trg && !tok) q_err.push_back(k);
            if (grant) m_perf = 0;
            else if (was_active) m_perf++;
            delta = 0;
            if (m_active && m_done_seen && k == m_done_edge + 1) begin
                m_active = 0; m_done_seen = 0; delta--; m_retired++;
            end else if (m_active && !m_done_seen && dn && k >= m_start + 2) begin
                m_done_seen = 1; m_done_edge = k;
                m_last_src = m_jobs.pop_front();
                q_evt.push_back(k); q_src.push_back(m_last_src);
            end else if (!was_active && m_occ > 0) begin
                m_active = 1; m_start = k; q_start.push_back(k);
            end
            if (tok) begin
                m_jobs.push_back(m_owner); delta++; m_trig++; m_locked = 0;
            end
            if (grant) begin
                m_locked = 1; m_owner = asrc;
            end
            m_occ += delta;
        end
        s.ed = k; s.crit = m_locked; s.full = (m_occ == NCTX);
        s.busy = (m_occ != 0) || m_active;
        s.ptr = m_trig % NCTX; s.run = m_retired % NCTX; s.perf = m_perf; s.src = m_last_src;
        q_lvl.push_back(s);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        bit exp;
        snap_t s;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk("reset_outputs", {20'd0, is_critical_o, full_context_o, acquire_grant_o,
                    trigger_err_o, pointer_context_o, running_context_o, engine_start_o,
                    true_done_o, evt_o, busy_o, |evt_src_o}, 32'd0);
                continue;
            end
            exp = (q_grant.size() > 0) && (q_grant[0] == edge_cnt);
            if (exp) void'(q_grant.pop_front());
            if (exp || acquire_grant_o) chk("acquire_grant", 32'(acquire_grant_o), 32'(exp));
            exp = (q_err.size() > 0) && (q_err[0] == edge_cnt);
            if (exp) void'(q_err.pop_front());
            if (exp || trigger_err_o) chk("trigger_err", 32'(trigger_err_o), 32'(exp));
            exp = (q_start.size() > 0) && (q_start[0] == edge_cnt);
            if (exp) void'(q_start.pop_front());
            if (exp || engine_start_o) chk("engine_start", 32'(engine_start_o), 32'(exp));
            exp = (q_evt.size() > 0) && (q_evt[0] == edge_cnt);
            if (exp || evt_o || true_done_o) begin
                chk("evt", 32'(evt_o), 32'(exp));
                chk("true_done", 32'(true_done_o), 32'(exp));
            end
            if (exp) begin
                void'(q_evt.pop_front());
                chk("evt_src", 32'(evt_src_o), 32'(q_src.pop_front()));
            end
            if ((q_lvl.size() > 0) && (q_lvl[0].ed == edge_cnt)) begin
                s = q_lvl.pop_front();
                chk("is_critical", 32'(is_critical_o), 32'(s.crit));
                chk("full_context", 32'(full_context_o), 32'(s.full));
                chk("busy", 32'(busy_o), 32'(s.busy));
                chk("pointer_context", 32'(pointer_context_o), 32'(s.ptr));
                chk("running_context", 32'(running_context_o), 32'(s.run));
                chk("evt_src_level", 32'(evt_src_o), 32'(s.src));
`ifdef HWPE_CTRL_SCHED_PERF_EN
                chk("perf_cnt", perf_cnt_o, 32'(s.perf));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        // Directed opening: lock, contention, queueing to full, completion, wrap.
        step(0, 0, 0, 0, 0, 0); @(negedge clk);
        step(0, 1, 3, 0, 0, 0); @(negedge clk);
        step(0, 1, 1, 1, 1, 0); @(negedge clk);
        step(0, 0, 0, 1, 3, 0); @(negedge clk);
        step(0, 1, 3, 0, 0, 0); @(negedge clk);
        step(0, 0, 0, 1, 3, 0); @(negedge clk);
        step(0, 1, 5, 0, 0, 0); @(negedge clk);
        repeat (10) begin step(0, 0, 0, 0, 0, 0); @(negedge clk); end
        step(0, 0, 0, 0, 0, 1); @(negedge clk);
        step(0, 1, 3, 0, 0, 0); @(negedge clk);
        step(0, 0, 0, 0, 0, 0); @(negedge clk);
        step(0, 0, 0, 0, 0, 1); @(negedge clk);
        step(0, 0, 0, 1, 3, 0); @(negedge clk);
        repeat (4) begin step(0, 0, 0, 0, 0, 0); @(negedge clk); end
        step(1, 0, 0, 0, 0, 0); @(negedge clk);
        step(0, 0, 0, 0, 0, 1); @(negedge clk);
        repeat (3) begin step(0, 0, 0, 0, 0, 0); @(negedge clk); end
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit clr, acq, trg, dn;
            logic [IDW-1:0] asrc, tsrc;
            clr  = ($urandom_range(0, 199) == 0);
            acq  = ($urandom_range(0, 3) == 0);
            asrc = IDW'($urandom_range(0, 3));
            trg  = ($urandom_range(0, 2) == 0);
            tsrc = ($urandom_range(0, 3) != 0) ? m_owner : IDW'($urandom_range(0, 3));
            dn   = ($urandom_range(0, 3) == 0);
            step(clr, acq, asrc, trg, tsrc, dn);
            @(negedge clk);
        end
        repeat (4) begin step(0, 0, 0, 0, 0, 0); @(negedge clk); end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
